hazard_sb: RTL and testbench

- Parametrised next-generation hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W).
- Holds an internal scoreboard: destination register and Tnew for each of the E, M and W stages. The unit pipelines this scoreboard itself from D-stage decode info, so it no longer re-decodes ir_e, ir_m and ir_w.
- Adds a multi-cycle mult/div busy tracker with configurable latencies.
- Outputs are the global stall and the forwarding mux selects for D, E and M.

---
 rtl/hazard_sb_if.sv | 48 ++++
 rtl/hazard_sb.sv | 142 ++++++++++++++
 tb/tb_hazard_sb.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_sb_if.sv
// Hazard unit D-stage decode bundle plus stall/forwarding result bundle.
// Latency: none, wires only.
// Backpressure: the stall output is the only flow control for the F/D and D/E registers.
//
// Signals:
//   rs_d, rt_d, wa_d          register fields of the instruction in D (wa_d = 0 means no write)
//   tuse_rs_d, tuse_rt_d      cycles until the source is needed; all-ones means the source is not read
//   tnew_d                    cycles after entering E until the result exists
//   md_start_d/md_div_d/md_use_d   mult/div start, divide select, any md-unit use
//   stall, md_busy            global freeze and md-unit busy
//   rsd_sel, rtd_sel          D forwarding: 0=RF 1=E 2=M 3=W
//   rse_sel, rte_sel          E forwarding: 0=pipe 1=M 2=W
//   rtm_sel                   M forwarding: 0=pipe 1=W
interface hazard_sb_if #(
    parameter int RA_W = 5,
    parameter int TN_W = 2
);
    logic [RA_W-1:0] rs_d;
    logic [RA_W-1:0] rt_d;
    logic [TN_W-1:0] tuse_rs_d;
    logic [TN_W-1:0] tuse_rt_d;
    logic [RA_W-1:0] wa_d;
    logic [TN_W-1:0] tnew_d;
    logic            md_start_d;
    logic            md_div_d;
    logic            md_use_d;
    logic            stall;
    logic            md_busy;
    logic [1:0]      rsd_sel;
    logic [1:0]      rtd_sel;
    logic [1:0]      rse_sel;
    logic [1:0]      rte_sel;
    logic            rtm_sel;

    // Pipeline control side: supplies decode info, consumes stall/selects.
    modport master (
        output rs_d, rt_d, tuse_rs_d, tuse_rt_d, wa_d, tnew_d,
               md_start_d, md_div_d, md_use_d,
        input  stall, md_busy, rsd_sel, rtd_sel, rse_sel, rte_sel, rtm_sel
    );

    // Hazard unit side.
    modport slave (
        input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, wa_d, tnew_d,
               md_start_d, md_div_d, md_use_d,
        output stall, md_busy, rsd_sel, rtd_sel, rse_sel, rte_sel, rtm_sel
    );
endinterface

// File: rtl/hazard_sb.sv
// Scoreboard-based hazard unit for a 5-stage MIPS pipeline: stall + forwarding selects, md busy tracking.
// Latency: stall and selects are combinational from D inputs and the registered E/M/W scoreboard.
// Backpressure: stall freezes PC and F/D and injects a bubble into E; the unit itself never blocks.
//
// Ports: clk, reset (synchronous, active-high), hz (hazard_sb_if.slave: D decode in, stall/selects out).
// Optional: define HAZARD_STALL_CNT_EN to add output stall_cnt[31:0], a saturating count of stall cycles.
// CNT_W must satisfy 2**CNT_W > max(MULT_CYC, DIV_CYC).
module hazard_sb #(
    parameter int RA_W     = 5,
    parameter int TN_W     = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    hazard_sb_if.slave  hz
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [TN_W-1:0] TUSE_NONE = '1;

    typedef struct packed {
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic [RA_W-1:0] wa;
        logic [TN_W-1:0] tnew;
        logic            md_start;
        logic            md_div;
    } e_rec_t;

    typedef struct packed {
        logic [RA_W-1:0] rt;
        logic [RA_W-1:0] wa;
        logic [TN_W-1:0] tnew;
    } m_rec_t;

    e_rec_t           e_q;
    e_rec_t           d_rec;
    m_rec_t           m_q;
    logic [RA_W-1:0]  w_wa_q;
    logic [CNT_W-1:0] md_cnt;
    logic             stall_reg;
    logic             stall_md;
    logic             stall;
    logic [TN_W-1:0]  e_tnew_dec;

    // A source stalls when a producer in E or M will not have its result
    // ready by the time this consumer needs it.
    function automatic logic src_hazard(input logic [RA_W-1:0] src,
                                        input logic [TN_W-1:0] tuse);
        logic hit;
        hit = 1'b0;
        if (tuse != TUSE_NONE && src != '0) begin
            if (e_q.wa == src && e_q.tnew > tuse) hit = 1'b1;
            if (m_q.wa == src && m_q.tnew > tuse) hit = 1'b1;
        end
        return hit;
    endfunction

    // D forwarding: nearest stage whose result already exists wins. W is
    // included because the register file does not write through.
    function automatic logic [1:0] fwd_d(input logic [RA_W-1:0] src);
        logic [1:0] sel;
        sel = 2'd0;
        if (src != '0) begin
            if (e_q.wa == src && e_q.tnew == '0)      sel = 2'd1;
            else if (m_q.wa == src && m_q.tnew == '0) sel = 2'd2;
            else if (w_wa_q == src)                   sel = 2'd3;
        end
        return sel;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [RA_W-1:0] src);
        logic [1:0] sel;
        sel = 2'd0;
        if (src != '0) begin
            if (m_q.wa == src && m_q.tnew == '0) sel = 2'd1;
            else if (w_wa_q == src)              sel = 2'd2;
        end
        return sel;
    endfunction

    always_comb begin
        d_rec          = '0;
        d_rec.rs       = hz.rs_d;
        d_rec.rt       = hz.rt_d;
        d_rec.wa       = hz.wa_d;
        d_rec.tnew     = hz.tnew_d;
        d_rec.md_start = hz.md_start_d;
        d_rec.md_div   = hz.md_div_d;
    end

    assign e_tnew_dec = (e_q.tnew == '0) ? '0 : e_q.tnew - TN_W'(1);

    assign stall_reg = src_hazard(hz.rs_d, hz.tuse_rs_d) |
                       src_hazard(hz.rt_d, hz.tuse_rt_d);
    // An md op sitting in E has not loaded the counter yet, so it counts as busy too.
    assign stall_md  = hz.md_use_d & ((md_cnt != '0) | e_q.md_start);
    assign stall     = stall_reg | stall_md;

    assign hz.stall   = stall;
    assign hz.md_busy = (md_cnt != '0);
    assign hz.rsd_sel = fwd_d(hz.rs_d);
    assign hz.rtd_sel = fwd_d(hz.rt_d);
    assign hz.rse_sel = fwd_e(e_q.rs);
    assign hz.rte_sel = fwd_e(e_q.rt);
    assign hz.rtm_sel = (w_wa_q != '0) && (m_q.rt == w_wa_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q    <= '0;
            m_q    <= '0;
            w_wa_q <= '0;
            md_cnt <= '0;
        end else begin
            e_q     <= stall ? '0 : d_rec;
            m_q.rt  <= e_q.rt;
            m_q.wa  <= e_q.wa;
            m_q.tnew <= e_tnew_dec;
            w_wa_q  <= m_q.wa;
            // A new md op reloads even if the previous count is just expiring.
            if (e_q.md_start)
                md_cnt <= e_q.md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - CNT_W'(1);
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Self-checking bench for hazard_sb: directed pipeline scenarios plus random decode streams vs a model.
// Latency: checks combinational outputs 1ns after inputs change at the falling edge.
// Backpressure: a stalled D instruction is held on the inputs until it is accepted.
module tb_hazard_sb;
    localparam int RA_W     = 5;
    localparam int TN_W     = 2;
    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;
    localparam int CNT_W    = 4;
    localparam int TUSE_NONE = (1 << TN_W) - 1;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    hazard_sb_if #(.RA_W(RA_W), .TN_W(TN_W)) hz ();
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    hazard_sb #(
        .RA_W(RA_W), .TN_W(TN_W), .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hz(hz)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    typedef struct {
        int rs; int rt; int tuse_rs; int tuse_rt; int wa; int tnew;
        bit mds; bit mdd; bit mdu;
    } ins_t;

    ins_t    cur;
    ins_t    pipe [3];          // 0=E, 1=M, 2=W
    int      cyc;
    int      md_enter, md_free; // md op was in E at cycle md_enter; unit free from md_free on
    longint  stalls;
    bit      e_stall, e_busy;
    int      e_rsd, e_rtd, e_rse, e_rte, e_rtm;

    function automatic ins_t zero_i();
        ins_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic ins_t nop_i();
        ins_t r;
        r = zero_i();
        r.tuse_rs = TUSE_NONE;
        r.tuse_rt = TUSE_NONE;
        return r;
    endfunction

    function automatic ins_t rand_i();
        ins_t r;
        r.rs      = $urandom_range(0, 7);
        r.rt      = $urandom_range(0, 7);
        r.tuse_rs = $urandom_range(0, 3);
        r.tuse_rt = $urandom_range(0, 3);
        r.wa      = $urandom_range(0, 7);
        r.tnew    = $urandom_range(0, 2);
        r.mds     = ($urandom_range(0, 9) == 0);
        r.mdd     = $urandom_range(0, 1);
        r.mdu     = r.mds | ($urandom_range(0, 5) == 0);
        return r;
    endfunction

    // Remaining cycles until the result exists, for the instruction at stage k.
    function automatic int eff_tnew(int k);
        int t;
        if (k >= 2) return 0;
        t = pipe[k].tnew - k;
        return (t > 0) ? t : 0;
    endfunction

    function automatic bit reg_hz(int src, int tuse);
        if (tuse == TUSE_NONE || src == 0) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (pipe[k].wa == src && eff_tnew(k) > tuse) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int fwd_d(int src);
        if (src == 0) return 0;
        for (int k = 0; k < 3; k++)
            if (pipe[k].wa == src && eff_tnew(k) == 0) return k + 1;
        return 0;
    endfunction

    function automatic int fwd_e(int src);
        if (src == 0) return 0;
        for (int k = 1; k < 3; k++)
            if (pipe[k].wa == src && eff_tnew(k) == 0) return k;
        return 0;
    endfunction

    task automatic model_expect();
        e_busy  = (cyc > md_enter) && (cyc < md_free);
        e_stall = reg_hz(cur.rs, cur.tuse_rs) || reg_hz(cur.rt, cur.tuse_rt) ||
                  (cur.mdu && (e_busy || pipe[0].mds));
        e_rsd = fwd_d(cur.rs);
        e_rtd = fwd_d(cur.rt);
        e_rse = fwd_e(pipe[0].rs);
        e_rte = fwd_e(pipe[0].rt);
        e_rtm = (pipe[2].wa != 0 && pipe[1].rt == pipe[2].wa) ? 1 : 0;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) pipe[k] = zero_i();
        md_enter = -100;
        md_free  = -100;
        stalls   = 0;
    endtask

    task automatic set_d(input ins_t i);
        cur           = i;
        hz.rs_d       = RA_W'(i.rs);
        hz.rt_d       = RA_W'(i.rt);
        hz.tuse_rs_d  = TN_W'(i.tuse_rs);
        hz.tuse_rt_d  = TN_W'(i.tuse_rt);
        hz.wa_d       = RA_W'(i.wa);
        hz.tnew_d     = TN_W'(i.tnew);
        hz.md_start_d = i.mds;
        hz.md_div_d   = i.mdd;
        hz.md_use_d   = i.mdu;
    endtask

    // One clock: advance the model alongside the DUT, return at the falling edge.
    task automatic tick();
        model_expect();
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            if (pipe[0].mds) begin
                md_enter = cyc;
                md_free  = cyc + (pipe[0].mdd ? DIV_CYC : MULT_CYC) + 1;
            end
            if (e_stall) stalls++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = e_stall ? zero_i() : cur;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic flush();
        set_d(nop_i());
        repeat (3) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_d(nop_i());
        #1;
        total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", hz.stall); end
        total++; if (hz.md_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", hz.md_busy); end
        total++; if ({hz.rsd_sel, hz.rtd_sel, hz.rse_sel, hz.rte_sel, hz.rtm_sel} !== 9'd0) begin
            bad++; $display("FAIL reset_sels got %b want 0", {hz.rsd_sel, hz.rtd_sel, hz.rse_sel, hz.rte_sel, hz.rtm_sel});
        end
`ifdef HAZARD_STALL_CNT_EN
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
`endif
    endtask

    task automatic test_load_use();
        ins_t lw, beq;
        int   n;
        flush();
        lw = nop_i(); lw.wa = 1; lw.tnew = 2;
        set_d(lw); #1;
        total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL lw_stall got %b want 0", hz.stall); end
        tick();
        beq = nop_i(); beq.rs = 1; beq.tuse_rs = 0; beq.rt = 5; beq.tuse_rt = 0;
        set_d(beq); #1;
        n = 0;
        for (int c = 0; c < 8 && hz.stall === 1'b1; c++) begin n++; tick(); #1; end
        total++; if (n !== 2) begin bad++; $display("FAIL load_use_stall_cycles got %0d want 2", n); end
        total++; if (hz.rsd_sel !== 2'd3) begin bad++; $display("FAIL load_use_rsd got %0d want 3", hz.rsd_sel); end
        total++; if (hz.rtd_sel !== 2'd0) begin bad++; $display("FAIL load_use_rtd got %0d want 0", hz.rtd_sel); end
        tick();
    endtask

    task automatic test_alu_fwd();
        ins_t a, b;
        flush();
        a = nop_i(); a.wa = 2; a.tnew = 1;
        set_d(a); #1; tick();
        b = nop_i(); b.rs = 2; b.tuse_rs = 1; b.wa = 4; b.tnew = 1;
        set_d(b); #1;
        total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL alu_stall got %b want 0", hz.stall); end
        total++; if (hz.rsd_sel !== 2'd0) begin bad++; $display("FAIL alu_rsd got %0d want 0", hz.rsd_sel); end
        tick();
        set_d(nop_i()); #1;
        total++; if (hz.rse_sel !== 2'd1) begin bad++; $display("FAIL alu_rse got %0d want 1", hz.rse_sel); end
        total++; if (hz.rte_sel !== 2'd0) begin bad++; $display("FAIL alu_rte got %0d want 0", hz.rte_sel); end
        tick();
    endtask

    task automatic test_jal_jr();
        ins_t jal, jr;
        flush();
        jal = nop_i(); jal.wa = 31; jal.tnew = 0;
        set_d(jal); #1; tick();
        jr = nop_i(); jr.rs = 31; jr.tuse_rs = 0;
        set_d(jr); #1;
        total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL jr_stall got %b want 0", hz.stall); end
        total++; if (hz.rsd_sel !== 2'd1) begin bad++; $display("FAIL jr_rsd got %0d want 1", hz.rsd_sel); end
        tick();
    endtask

    task automatic test_div_mflo();
        ins_t dv, mf;
        int   n_stall, n_busy;
        flush();
        dv = nop_i(); dv.rs = 8; dv.rt = 9; dv.tuse_rs = 1; dv.tuse_rt = 1;
        dv.mds = 1; dv.mdd = 1; dv.mdu = 1;
        set_d(dv); #1;
        total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL div_stall got %b want 0", hz.stall); end
        tick();
        mf = nop_i(); mf.wa = 3; mf.tnew = 1; mf.mdu = 1;
        set_d(mf); #1;
        n_stall = 0; n_busy = 0;
        for (int c = 0; c < 20; c++) begin
            if (hz.stall === 1'b1) n_stall++;
            if (hz.md_busy === 1'b1) n_busy++;
            tick(); #1;
        end
        total++; if (n_stall !== DIV_CYC + 1) begin bad++; $display("FAIL mflo_stall_cycles got %0d want %0d", n_stall, DIV_CYC + 1); end
        total++; if (n_busy !== DIV_CYC) begin bad++; $display("FAIL div_busy_cycles got %0d want %0d", n_busy, DIV_CYC); end
    endtask

    task automatic test_zero_reg();
        ins_t w0, r0;
        flush();
        w0 = nop_i(); w0.wa = 0; w0.tnew = 2;
        set_d(w0); #1; tick();
        r0 = nop_i(); r0.rs = 0; r0.rt = 0; r0.tuse_rs = 0; r0.tuse_rt = 0;
        set_d(r0);
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL zero_stall c=%0d got %b want 0", c, hz.stall); end
            total++; if ({hz.rsd_sel, hz.rtd_sel, hz.rse_sel, hz.rte_sel, hz.rtm_sel} !== 9'd0) begin
                bad++; $display("FAIL zero_sels c=%0d got %b want 0", c, {hz.rsd_sel, hz.rtd_sel, hz.rse_sel, hz.rte_sel, hz.rtm_sel});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_div();
        ins_t dv, mf;
        flush();
        dv = nop_i(); dv.mds = 1; dv.mdd = 1; dv.mdu = 1;
        set_d(dv); tick();
        mf = nop_i(); mf.mdu = 1; mf.wa = 3; mf.tnew = 1;
        set_d(mf);
        repeat (3) tick();
        #1;
        total++; if (hz.md_busy !== 1'b1) begin bad++; $display("FAIL mid_div_busy got %b want 1", hz.md_busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++; if (hz.md_busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got %b want 0", hz.md_busy); end
        total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL post_reset_stall got %b want 0", hz.stall); end
`ifdef HAZARD_STALL_CNT_EN
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL post_reset_stall_cnt got %0d want 0", stall_cnt); end
`endif
        tick();
    endtask

    task automatic test_random();
        ins_t i;
        bit   hold;
        hold = 1'b0;
        i = nop_i();
        for (int c = 0; c < 3000; c++) begin
            if (!hold) i = rand_i();
            set_d(i);
            reset = ($urandom_range(0, 299) == 0);
            #1;
            model_expect();
            total++; if (hz.stall !== e_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got %b want %b", cyc, hz.stall, e_stall); end
            total++; if (hz.md_busy !== e_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got %b want %b", cyc, hz.md_busy, e_busy); end
            total++; if (hz.rsd_sel !== 2'(e_rsd)) begin bad++; $display("FAIL rnd_rsd cyc=%0d got %0d want %0d", cyc, hz.rsd_sel, e_rsd); end
            total++; if (hz.rtd_sel !== 2'(e_rtd)) begin bad++; $display("FAIL rnd_rtd cyc=%0d got %0d want %0d", cyc, hz.rtd_sel, e_rtd); end
            total++; if (hz.rse_sel !== 2'(e_rse)) begin bad++; $display("FAIL rnd_rse cyc=%0d got %0d want %0d", cyc, hz.rse_sel, e_rse); end
            total++; if (hz.rte_sel !== 2'(e_rte)) begin bad++; $display("FAIL rnd_rte cyc=%0d got %0d want %0d", cyc, hz.rte_sel, e_rte); end
            total++; if (hz.rtm_sel !== 1'(e_rtm)) begin bad++; $display("FAIL rnd_rtm cyc=%0d got %0d want %0d", cyc, hz.rtm_sel, e_rtm); end
`ifdef HAZARD_STALL_CNT_EN
            total++; if (stall_cnt !== 32'(stalls)) begin bad++; $display("FAIL rnd_stall_cnt cyc=%0d got %0d want %0d", cyc, stall_cnt, stalls); end
`endif
            hold = e_stall && !reset;
            tick();
            reset = 1'b0;
        end
    endtask

    initial begin
        cyc   = 0;
        reset = 1'b1;
        model_clear();
        set_d(nop_i());
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_load_use();
        test_alu_fwd();
        test_jal_jr();
        test_div_mflo();
        test_zero_reg();
        test_reset_mid_div();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
